// File: rtl/issue_select_pkg.sv
// Shared constants, entry field positions and wakeup helpers for the issue-select stage.
package issue_select_pkg;

  localparam int NUM_IQ_ENTRIES      = 8;
  localparam int NUM_IQ_ENTRIES_LOG2 = 3;
  localparam int IQ_ENTRY_SIZE       = 32;
  localparam int NUM_PREGS           = 64;
  localparam int PREG_LOG2           = 6;

  localparam int IQ_VLD          = 31;
  localparam int IQ_OP_MSB       = 30;
  localparam int IQ_OP_LSB       = 25;
  localparam int IQ_DST_MSB      = 24;
  localparam int IQ_DST_LSB      = 19;
  localparam int IQ_SRC0_MSB     = 18;
  localparam int IQ_SRC0_LSB     = 13;
  localparam int IQ_SRC0_EN      = 12;
  localparam int IQ_SRC1_MSB     = 11;
  localparam int IQ_SRC1_LSB     = 6;
  localparam int IQ_SRC1_EN      = 5;
  localparam int IQ_ROB_MSB      = 4;
  localparam int IQ_ROB_LSB      = 0;

  typedef logic [IQ_ENTRY_SIZE-1:0]       iq_entry_t;
  typedef logic [PREG_LOG2-1:0]           preg_t;
  typedef logic [NUM_IQ_ENTRIES_LOG2-1:0] iq_idx_t;

  function automatic preg_t f_dst(input iq_entry_t e);
    return e[IQ_DST_MSB:IQ_DST_LSB];
  endfunction

  function automatic preg_t f_src0(input iq_entry_t e);
    return e[IQ_SRC0_MSB:IQ_SRC0_LSB];
  endfunction

  function automatic preg_t f_src1(input iq_entry_t e);
    return e[IQ_SRC1_MSB:IQ_SRC1_LSB];
  endfunction

  // Source is ready when unused, already written, or being written back this cycle.
  function automatic logic f_src_rdy(input preg_t tag, input logic en,
                                     input logic [NUM_PREGS-1:0] ready,
                                     input logic wb_vld0, input preg_t wb_tag0,
                                     input logic wb_vld1, input preg_t wb_tag1);
    return !en || ready[tag] || (wb_vld0 && (wb_tag0 == tag)) ||
           (wb_vld1 && (wb_tag1 == tag));
  endfunction

  function automatic logic f_uses_tag(input iq_entry_t e, input preg_t tag);
    return (e[IQ_SRC0_EN] && (f_src0(e) == tag)) ||
           (e[IQ_SRC1_EN] && (f_src1(e) == tag));
  endfunction

endpackage

// File: rtl/issue_select_scoreboard.sv
// Physical-register ready bits: two writeback set ports, two issue clear ports.
// A clear beats a set of the same tag in the same cycle; flush marks everything ready.
module issue_select_scoreboard
  import issue_select_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_set_vld0,
  input  logic [PREG_LOG2-1:0] i_set_tag0,
  input  logic                 i_set_vld1,
  input  logic [PREG_LOG2-1:0] i_set_tag1,
  input  logic                 i_clr_vld0,
  input  logic [PREG_LOG2-1:0] i_clr_tag0,
  input  logic                 i_clr_vld1,
  input  logic [PREG_LOG2-1:0] i_clr_tag1,
  output logic [NUM_PREGS-1:0] o_ready
);

  logic [NUM_PREGS-1:0] r_ready;
  logic [NUM_PREGS-1:0] w_set;
  logic [NUM_PREGS-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_vld0) w_set[i_set_tag0] = 1'b1;
    if (i_set_vld1) w_set[i_set_tag1] = 1'b1;
    if (i_clr_vld0) w_clr[i_clr_tag0] = 1'b1;
    if (i_clr_vld1) w_clr[i_clr_tag1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= '1;
    end else if (i_flush) begin
      r_ready <= '1;
    end else begin
      r_ready <= (r_ready | w_set) & ~w_clr;
    end
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/issue_select.sv
// Wakeup, dual select and issue-slot registers downstream of the 8-entry issue queue.
// Pops are combinational so the queue drops an entry on the same edge the slot loads it.
module issue_select
  import issue_select_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data0,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data1,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data2,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data3,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data4,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data5,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data6,
  input  logic [IQ_ENTRY_SIZE-1:0] iq_data7,
  output logic                     pop0,
  output logic [2:0]               pop_key0,
  output logic                     pop1,
  output logic [2:0]               pop_key1,
  input  logic                     wb_vld0,
  input  logic                     wb_vld1,
  input  logic [PREG_LOG2-1:0]     wb_tag0,
  input  logic [PREG_LOG2-1:0]     wb_tag1,
  output logic                     iss_vld0,
  output logic                     iss_vld1,
  output logic [IQ_ENTRY_SIZE-1:0] iss_data0,
  output logic [IQ_ENTRY_SIZE-1:0] iss_data1,
  input  logic                     iss_rdy0,
  input  logic                     iss_rdy1
);

  iq_entry_t                 w_entry [NUM_IQ_ENTRIES];
  logic [NUM_PREGS-1:0]      w_ready;
  logic [NUM_IQ_ENTRIES-1:0] w_elig;
  logic [NUM_IQ_ENTRIES-1:0] w_b_cand;
  logic                      w_a_vld;
  iq_idx_t                   w_a_idx;
  preg_t                     w_a_dst;
  logic                      w_b_vld;
  iq_idx_t                   w_b_idx;
  logic                      w_acc0;
  logic                      w_acc1;
  logic                      w_go;
  logic                      w_pick0;
  logic                      w_pick1;
  iq_idx_t                   w_key0;
  iq_idx_t                   w_key1;

  logic                      r_iss_vld0;
  logic                      r_iss_vld1;
  iq_entry_t                 r_iss_data0;
  iq_entry_t                 r_iss_data1;

  assign w_entry[0] = iq_data0;
  assign w_entry[1] = iq_data1;
  assign w_entry[2] = iq_data2;
  assign w_entry[3] = iq_data3;
  assign w_entry[4] = iq_data4;
  assign w_entry[5] = iq_data5;
  assign w_entry[6] = iq_data6;
  assign w_entry[7] = iq_data7;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
      w_elig[i] = w_entry[i][IQ_VLD] &&
        f_src_rdy(f_src0(w_entry[i]), w_entry[i][IQ_SRC0_EN], w_ready,
                  wb_vld0, wb_tag0, wb_vld1, wb_tag1) &&
        f_src_rdy(f_src1(w_entry[i]), w_entry[i][IQ_SRC1_EN], w_ready,
                  wb_vld0, wb_tag0, wb_vld1, wb_tag1);
    end
  end

  always_comb begin
    w_a_vld = 1'b0;
    w_a_idx = '0;
    for (int i = NUM_IQ_ENTRIES - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_a_vld = 1'b1;
        w_a_idx = NUM_IQ_ENTRIES_LOG2'(i);
      end
    end
  end

  assign w_a_dst = f_dst(w_entry[w_a_idx]);

  // Pick B must not read pick A's destination; A has not written it yet.
  always_comb begin
    w_b_cand = '0;
    for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
      w_b_cand[i] = w_elig[i] && (NUM_IQ_ENTRIES_LOG2'(i) != w_a_idx) &&
                    !f_uses_tag(w_entry[i], w_a_dst);
    end
  end

  always_comb begin
    w_b_vld = 1'b0;
    w_b_idx = '0;
    for (int i = NUM_IQ_ENTRIES - 1; i >= 0; i--) begin
      if (w_b_cand[i]) begin
        w_b_vld = 1'b1;
        w_b_idx = NUM_IQ_ENTRIES_LOG2'(i);
      end
    end
  end

  assign w_acc0 = !r_iss_vld0 || iss_rdy0;
  assign w_acc1 = !r_iss_vld1 || iss_rdy1;
  assign w_go   = rst_n && !flush;

  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    w_key0  = '0;
    w_key1  = '0;
    if (w_go && w_a_vld) begin
      if (w_acc0) begin
        w_pick0 = 1'b1;
        w_key0  = w_a_idx;
        if (w_acc1 && w_b_vld) begin
          w_pick1 = 1'b1;
          w_key1  = w_b_idx;
        end
      end else if (w_acc1) begin
        w_pick1 = 1'b1;
        w_key1  = w_a_idx;
      end
    end
  end

  assign pop0     = w_pick0;
  assign pop_key0 = w_key0;
  assign pop1     = w_pick1;
  assign pop_key1 = w_key1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_vld0  <= 1'b0;
      r_iss_data0 <= '0;
    end else if (flush) begin
      r_iss_vld0  <= 1'b0;
      r_iss_data0 <= '0;
    end else if (w_pick0) begin
      r_iss_vld0  <= 1'b1;
      r_iss_data0 <= w_entry[w_key0];
    end else if (iss_rdy0) begin
      r_iss_vld0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_vld1  <= 1'b0;
      r_iss_data1 <= '0;
    end else if (flush) begin
      r_iss_vld1  <= 1'b0;
      r_iss_data1 <= '0;
    end else if (w_pick1) begin
      r_iss_vld1  <= 1'b1;
      r_iss_data1 <= w_entry[w_key1];
    end else if (iss_rdy1) begin
      r_iss_vld1  <= 1'b0;
    end
  end

  assign iss_vld0  = r_iss_vld0;
  assign iss_vld1  = r_iss_vld1;
  assign iss_data0 = r_iss_data0;
  assign iss_data1 = r_iss_data1;

  issue_select_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_set_vld0 (wb_vld0),
    .i_set_tag0 (wb_tag0),
    .i_set_vld1 (wb_vld1),
    .i_set_tag1 (wb_tag1),
    .i_clr_vld0 (w_pick0),
    .i_clr_tag0 (f_dst(w_entry[w_key0])),
    .i_clr_vld1 (w_pick1),
    .i_clr_tag1 (f_dst(w_entry[w_key1])),
    .o_ready    (w_ready)
  );

endmodule

// File: tb/tb_issue_select.sv
// Directed bench: stimulus pushes expected pops/issues (with cycle stamps) into queues,
// a negedge monitor pops and compares whenever the DUT presents a pop or a newly loaded slot.
module tb_issue_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] iq [8];
  logic        pop0, pop1;
  logic [2:0]  pop_key0, pop_key1;
  logic        wb_vld0, wb_vld1;
  logic [5:0]  wb_tag0, wb_tag1;
  logic        iss_vld0, iss_vld1;
  logic [31:0] iss_data0, iss_data1;
  logic        iss_rdy0, iss_rdy1;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } rec_t;

  rec_t q_pop0[$], q_pop1[$], q_iss0[$], q_iss1[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic        pv0 = 1'b0, pv1 = 1'b0, pr0 = 1'b0, pr1 = 1'b0, pf = 1'b0;
  logic [31:0] pd0 = '0, pd1 = '0;

  issue_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .iq_data0  (iq[0]),
    .iq_data1  (iq[1]),
    .iq_data2  (iq[2]),
    .iq_data3  (iq[3]),
    .iq_data4  (iq[4]),
    .iq_data5  (iq[5]),
    .iq_data6  (iq[6]),
    .iq_data7  (iq[7]),
    .pop0      (pop0),
    .pop_key0  (pop_key0),
    .pop1      (pop1),
    .pop_key1  (pop_key1),
    .wb_vld0   (wb_vld0),
    .wb_vld1   (wb_vld1),
    .wb_tag0   (wb_tag0),
    .wb_tag1   (wb_tag1),
    .iss_vld0  (iss_vld0),
    .iss_vld1  (iss_vld1),
    .iss_data0 (iss_data0),
    .iss_data1 (iss_data1),
    .iss_rdy0  (iss_rdy0),
    .iss_rdy1  (iss_rdy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int dst, input int s0, input int e0,
                                     input int s1, input int e1, input int rob);
    return {1'b1, 6'(rob + 1), 6'(dst), 6'(s0), 1'(e0), 6'(s1), 1'(e1), 5'(rob)};
  endfunction

  // Expected pick: pop this cycle on the given slot, slot presents the entry next cycle.
  task automatic expect_pick(input int slot, input int key, input logic [31:0] data);
    rec_t p, d;
    p.cyc = cyc;     p.val = 32'(key);
    d.cyc = cyc + 1; d.val = data;
    if (slot == 0) begin q_pop0.push_back(p); q_iss0.push_back(d); end
    else           begin q_pop1.push_back(p); q_iss1.push_back(d); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    rec_t r;
    if (rst_n) begin
      if (pop0) begin
        if (q_pop0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop0_unexpected: got key %0d at cycle %0d, required no pop", pop_key0, cyc);
        end else begin
          r = q_pop0.pop_front();
          check("pop0_key_cycle", {32'(cyc), 29'd0, pop_key0}, {32'(r.cyc), r.val});
        end
      end else check("pop_key0_idle", 64'(pop_key0), 64'd0);
      if (pop1) begin
        if (q_pop1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop1_unexpected: got key %0d at cycle %0d, required no pop", pop_key1, cyc);
        end else begin
          r = q_pop1.pop_front();
          check("pop1_key_cycle", {32'(cyc), 29'd0, pop_key1}, {32'(r.cyc), r.val});
        end
      end else check("pop_key1_idle", 64'(pop_key1), 64'd0);

      if (iss_vld0 && (!pv0 || pr0)) begin
        if (q_iss0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL iss0_unexpected: got %h at cycle %0d, required slot idle", iss_data0, cyc);
        end else begin
          r = q_iss0.pop_front();
          check("iss0_data_cycle", {32'(cyc), iss_data0}, {32'(r.cyc), r.val});
        end
      end
      if (iss_vld1 && (!pv1 || pr1)) begin
        if (q_iss1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL iss1_unexpected: got %h at cycle %0d, required slot idle", iss_data1, cyc);
        end else begin
          r = q_iss1.pop_front();
          check("iss1_data_cycle", {32'(cyc), iss_data1}, {32'(r.cyc), r.val});
        end
      end
      if (pv0 && !pr0 && !pf) check("iss0_hold", {31'd0, iss_vld0, iss_data0}, {31'd0, 1'b1, pd0});
      if (pv1 && !pr1 && !pf) check("iss1_hold", {31'd0, iss_vld1, iss_data1}, {31'd0, 1'b1, pd1});
      pv0 = iss_vld0; pv1 = iss_vld1; pr0 = iss_rdy0; pr1 = iss_rdy1;
      pd0 = iss_data0; pd1 = iss_data1; pf = flush;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    wb_vld0 = 1'b0; wb_vld1 = 1'b0; wb_tag0 = '0; wb_tag1 = '0;
    iss_rdy0 = 1'b0; iss_rdy1 = 1'b0;
    for (int i = 0; i < 8; i++) iq[i] = '0;
    tick(); tick();

    // Reset state, including pop suppression with an eligible entry present
    check("rst_iss_vld", {62'd0, iss_vld0, iss_vld1}, 64'd0);
    check("rst_iss_data", {iss_data0, iss_data1}, 64'd0);
    iq[1] = mk(5, 0, 0, 0, 0, 1);
    #1;
    check("rst_pops", {62'd0, pop0, pop1}, 64'd0);
    iq[1] = '0;
    rst_n = 1'b1;
    tick(); tick();

    // Two independent entries at idx 2 and 5
    iss_rdy0 = 1'b1; iss_rdy1 = 1'b1;
    iq[2] = mk(1, 0, 0, 0, 0, 2);
    iq[5] = mk(2, 0, 0, 0, 0, 5);
    expect_pick(0, 2, iq[2]);
    expect_pick(1, 5, iq[5]);
    tick();
    iq[2] = '0; iq[5] = '0;
    tick();

    // Dependence on pick A's dst, then bypass wakeup
    iq[0] = mk(10, 0, 0, 0, 0, 0);
    iq[1] = mk(11, 10, 1, 0, 0, 1);
    expect_pick(0, 0, iq[0]);
    tick();
    iq[0] = '0;
    tick();
    wb_vld0 = 1'b1; wb_tag0 = 6'd10;
    expect_pick(0, 1, iq[1]);
    tick();
    iq[1] = '0; wb_vld0 = 1'b0;
    tick();

    // Slot 0 blocked: pick A routes to slot 1, slot 0 holds
    iss_rdy0 = 1'b0;
    iq[6] = mk(30, 0, 0, 0, 0, 6);
    expect_pick(0, 6, iq[6]);
    tick();
    iq[6] = '0;
    iq[3] = mk(12, 0, 0, 0, 0, 3);
    iq[4] = mk(13, 0, 0, 0, 0, 4);
    expect_pick(1, 3, iq[3]);
    tick();
    iq[3] = '0;
    expect_pick(1, 4, iq[4]);
    tick();
    iq[4] = '0;
    tick();
    check("slot0_held_data", {31'd0, iss_vld0, iss_data0}, {31'd0, 1'b1, mk(30, 0, 0, 0, 0, 6)});
    iss_rdy0 = 1'b1;
    tick(); tick();

    // Writeback and issue of tag 20 in the same cycle: clear wins
    iq[7] = mk(20, 0, 0, 0, 0, 7);
    wb_vld1 = 1'b1; wb_tag1 = 6'd20;
    expect_pick(0, 7, iq[7]);
    tick();
    iq[7] = '0; wb_vld1 = 1'b0;
    iq[0] = mk(21, 0, 0, 20, 1, 8);
    tick(); tick();

    // Flush with both slots valid and eligible work waiting
    iss_rdy0 = 1'b0; iss_rdy1 = 1'b0;
    iq[2] = mk(40, 0, 0, 0, 0, 2);
    iq[3] = mk(41, 0, 0, 0, 0, 3);
    expect_pick(0, 2, iq[2]);
    expect_pick(1, 3, iq[3]);
    tick();
    iq[2] = '0; iq[3] = '0;
    iq[4] = mk(42, 0, 0, 0, 0, 4);
    iss_rdy0 = 1'b1; iss_rdy1 = 1'b1;
    flush = 1'b1;
    wb_vld0 = 1'b1; wb_tag0 = 6'd33;
    #1;
    check("flush_pops", {62'd0, pop0, pop1}, 64'd0);
    tick();
    flush = 1'b0; wb_vld0 = 1'b0;
    check("flush_iss_vld", {62'd0, iss_vld0, iss_vld1}, 64'd0);
    check("flush_iss_data", {iss_data0, iss_data1}, 64'd0);
    // Scoreboard all ready again: idx0 (waiting on tag 20) now eligible alongside idx4
    expect_pick(0, 0, iq[0]);
    expect_pick(1, 4, iq[4]);
    tick();
    iq[0] = '0; iq[4] = '0;
    tick(); tick(); tick();

    check("q_pop0_drained", 64'(q_pop0.size()), 64'd0);
    check("q_pop1_drained", 64'(q_pop1.size()), 64'd0);
    check("q_iss0_drained", 64'(q_iss0.size()), 64'd0);
    check("q_iss1_drained", 64'(q_iss1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Scheduling stage directly downstream of the 8-entry issue queue.
- Each cycle it scans the queue's eight entry outputs and wakes up entries whose sources are ready, using a physical-register scoreboard plus same-cycle writeback bypass.
- It selects up to two entries, drives the queue's pop0/pop_key0 and pop1/pop_key1, and registers the selected entries into two issue slots toward the execution units.

Parameters:
- NUM_IQ_ENTRIES, 8, entries scanned; fixed by the issue queue.
- NUM_PREGS, 64, physical registers tracked by the scoreboard.
- PREG_LOG2, 6, physical register tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush.
- iq_data0..iq_data7  in  IQ_ENTRY_SIZE(32) each  queue entry outputs; all-zero when the slot is empty.
- pop0  out  1  pop request to queue, slot 0 pick.
- pop_key0  out  3  index of the slot 0 pick.
- pop1  out  1  pop request, slot 1 pick.
- pop_key1  out  3  index of the slot 1 pick.
- wb_vld0, wb_vld1  in  1  writeback broadcast valid.
- wb_tag0, wb_tag1  in  6  writeback physical register tag.
- iss_vld0, iss_vld1  out  1  issue slot holds a valid entry.
- iss_data0, iss_data1  out  32  issued entry, registered.
- iss_rdy0, iss_rdy1  in  1  execution unit accepts the slot this cycle.

Behaviour:
- Entry layout, bit 31 down to 0:
  - valid [31], opcode [30:25], dst [24:19], src0 [18:13], src0_en [12], src1 [11:6], src1_en [5], rob [4:0].
  - An entry with valid=0 is never eligible.
- Scoreboard: NUM_PREGS ready bits.
  - Reset value is all 1.
  - Set at posedge for each valid writeback tag.
  - Cleared at posedge for the dst of each entry accepted into an issue slot.
  - Set and clear of the same tag in the same cycle: clear wins.
- Wakeup (combinational): a source is ready if its _en bit is 0, OR its scoreboard bit is 1, OR it matches a valid wb_tag0/wb_tag1 this cycle (bypass).
  - An entry is eligible when valid and both sources are ready.
- Slot accept condition: slot k can accept when iss_vld_k=0 OR iss_rdy_k=1.
- Select:
  - Pick A = lowest-index eligible entry. It goes to slot 0 if slot 0 can accept, else to slot 1 if slot 1 can accept.
  - Pick B = next-lowest eligible entry, excluding any entry with an enabled source equal to pick A's dst (same-cycle dependence). It goes to the remaining acceptable slot.
  - No acceptable slot means no pick.
- Pops:
  - pop0/pop_key0 carry the slot 0 pick; pop1/pop_key1 carry the slot 1 pick.
  - Pops are combinational, same cycle as selection. The queue invalidates the entry at the same edge the slot loads, so an entry is never double-issued.
  - pop_key is 0 when the corresponding pop is 0.
- Issue registers:
  - On posedge, slot k loads the pick when it has one; iss_vld_k becomes 1.
  - Else if iss_rdy_k=1, iss_vld_k becomes 0.
  - Else the slot holds, and iss_data_k stays stable while iss_vld_k=1 and iss_rdy_k=0.
- Latency: entry eligible in cycle N -> pop in cycle N, iss_vld=1 in cycle N+1.
- Reset: iss_vld0/1=0, iss_data0/1=0, scoreboard all 1. pop0/pop1 are 0 while rst_n=0.
- Flush:
  - pop0/pop1 forced to 0.
  - At posedge: iss_vld0/1 cleared, iss_data cleared to 0, scoreboard set all 1.
  - Writebacks in the flush cycle are ignored.
- Empty queue (all entries 0): no pops, slots drain normally.

Decomposition:
- Shared package/defines:
  - NUM_IQ_ENTRIES, NUM_IQ_ENTRIES_LOG2, IQ_ENTRY_SIZE.
  - Entry field MSB/LSB constants (IQ_VLD, IQ_OP, IQ_DST, IQ_SRC0, IQ_SRC0_EN, IQ_SRC1, IQ_SRC1_EN, IQ_ROB).
  - NUM_PREGS, PREG_LOG2.
- One sub-module: scoreboard.
  - Ready-bit array with two set ports, two clear ports and flush/reset.
  - Exposes the ready vector.
- Wakeup/select and the issue registers stay in issue_select.

Test Plan:
- Reset, queue empty -> iss_vld0/1=0, pop0/pop1=0; scoreboard all ready.
- Entries at idx 2 and 5 with src_en=0, both slots free -> pop0=1 key0=2, pop1=1 key1=5; next cycle iss_data0=entry2, iss_data1=entry5.
- Entry idx0 dst=10, entry idx1 src0=10 en=1, scoreboard ready[10]=1 -> only idx0 popped. Next cycle ready[10]=0, idx1 not eligible until wb_vld0=1 wb_tag0=10, then idx1 popped that same cycle via bypass.
- iss_vld0=1 iss_rdy0=0, iss_vld1=0, two eligible entries idx3, idx4 -> only idx3 popped, via pop1/key1=3. Slot 0 holds its data unchanged.
- Writeback tag 20 and issue with dst=20 in the same cycle -> ready[20]=0 after the edge.
- Flush with both slots valid and eligible entries present -> pop0/pop1=0 in the flush cycle; next cycle iss_vld0/1=0 and scoreboard all 1.
